// File: rtl/tramelblaze_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tramelblaze_intc_pkg
// Brief    : Port map defaults, FSM encoding and cause-word helper for the INTC
// Revision : 1.0
// ============================================================================
package tramelblaze_intc_pkg;

  localparam logic [15:0] C_PORT_CAUSE = 16'h00F0;
  localparam logic [15:0] C_PORT_PEND  = 16'h00F1;
  localparam logic [15:0] C_PORT_MASK  = 16'h00F2;
  localparam logic [15:0] C_PORT_EOI   = 16'h00F3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  function automatic logic [15:0] cause_word(input logic valid, input logic [3:0] id);
    return {valid, 11'b0, id};
  endfunction

endpackage
`default_nettype wire

// File: rtl/intc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : intc_prio_enc
// Brief    : Lowest-index-first priority encoder, reports {hit, id}
// Revision : 1.0
// ============================================================================
module intc_prio_enc #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req_i,
  output logic            hit_o,
  output logic [3:0]      id_o
);

  // Scan from the top down so the lowest set index is written last and wins.
  always_comb begin
    hit_o = |req_i;
    id_o  = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = 4'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tramelblaze_intc.sv
`default_nettype none
// ============================================================================
// Module   : tramelblaze_intc
// Brief    : Edge-latched interrupt controller driving TramelBlaze INTERRUPT
// Revision : 1.0
// ============================================================================
module tramelblaze_intc
  import tramelblaze_intc_pkg::*;
#(
  parameter int          NSRC       = 8,
  parameter logic [15:0] PORT_CAUSE = C_PORT_CAUSE,
  parameter logic [15:0] PORT_PEND  = C_PORT_PEND,
  parameter logic [15:0] PORT_MASK  = C_PORT_MASK,
  parameter logic [15:0] PORT_EOI   = C_PORT_EOI
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NSRC-1:0] IRQ_IN,
  input  logic [15:0]     PORT_ID,
  input  logic [15:0]     OUT_PORT,
  input  logic            WRITE_STROBE,
  input  logic            READ_STROBE,
  input  logic            INTERRUPT_ACK,
  output logic            INTERRUPT,
  output logic [15:0]     IN_PORT,
  output logic            BUSY
);

  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  intc_state_e     state_q, state_d;
  logic            int_q, int_d;
  logic            busy_q, busy_d;
  logic [3:0]      cause_id_q, cause_id_d;
  logic            cause_hit_q, cause_hit_d;

  logic            w_mask_wr;
  logic            w_eoi_wr;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_active;
  logic            w_hit;
  logic [3:0]      w_id;
  logic            w_unused;

  assign w_mask_wr = WRITE_STROBE && (PORT_ID == PORT_MASK);
  assign w_eoi_wr  = WRITE_STROBE && (PORT_ID == PORT_EOI);
  assign w_rise    = IRQ_IN & ~irq_q;
  assign w_active  = pending_q & mask_q;
  assign w_unused  = ^{READ_STROBE, OUT_PORT};

  intc_prio_enc #(.NSRC(NSRC)) u_prio_enc (
    .req_i (w_active),
    .hit_o (w_hit),
    .id_o  (w_id)
  );

  // A rising edge in the same cycle as an EOI clear is OR-ed back in afterwards.
  always_comb begin
    pending_d = pending_q;
    if (w_eoi_wr) pending_d = pending_q & ~OUT_PORT[NSRC-1:0];
    pending_d = pending_d | w_rise;
    mask_d    = w_mask_wr ? OUT_PORT[NSRC-1:0] : mask_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      irq_q     <= IRQ_IN;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    int_d       = int_q;
    busy_d      = busy_q;
    cause_id_d  = cause_id_q;
    cause_hit_d = cause_hit_q;
    case (state_q)
      ST_IDLE: begin
        int_d  = 1'b0;
        busy_d = 1'b0;
        if (|w_active) begin
          int_d   = 1'b1;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        int_d = 1'b1;
        // Capture is taken at ACK time; an emptied request yields hit=0.
        if (INTERRUPT_ACK) begin
          int_d       = 1'b0;
          busy_d      = 1'b1;
          cause_id_d  = w_id;
          cause_hit_d = w_hit;
          state_d     = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        int_d  = 1'b0;
        busy_d = 1'b1;
        if (w_eoi_wr) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        int_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      int_q       <= 1'b0;
      busy_q      <= 1'b0;
      cause_id_q  <= 4'd0;
      cause_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      busy_q      <= busy_d;
      cause_id_q  <= cause_id_d;
      cause_hit_q <= cause_hit_d;
    end
  end

  always_comb begin
    IN_PORT = 16'h0000;
    if (PORT_ID == PORT_CAUSE) begin
      IN_PORT = cause_word((state_q == ST_SERVICE) && cause_hit_q, cause_id_q);
    end else if (PORT_ID == PORT_PEND) begin
      IN_PORT[NSRC-1:0] = pending_q;
    end else if (PORT_ID == PORT_MASK) begin
      IN_PORT[NSRC-1:0] = mask_q;
    end
  end

  assign INTERRUPT = int_q;
  assign BUSY      = busy_q;

endmodule
`default_nettype wire
